ps2_keyboard: RTL and testbench
===============================

// Module: ps2_keyboard
// PURPOSE
//  PS/2 device-to-host receiver. Samples the keyboard clock/data lines in the system clock
//  domain, deframes 11-bit PS/2 frames and presents each received scan-code byte
//  (make codes, 0xF0 break prefix, 0xE0 extended prefix, all unfiltered) with a sticky ready
//  flag. Sits below the key decoder, which ties rst to ~ps2_state: reset acts as the read acknowledge.
// PARAMETERS
//  SYNC_STAGES    2      flip-flop stages synchronising ps2k_clk and ps2k_data (min 2)
//  TIMEOUT_CYCLES 50000  clk cycles without a ps2k_clk falling edge before a partial frame is dropped
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  asynchronous, active-low reset / ready acknowledge
//  ps2k_clk   in   1  raw PS/2 clock from keyboard (asynchronous, idle high)
//  ps2k_data  in   1  raw PS/2 data from keyboard (asynchronous, idle high)
//  ps2_byte   out  8  last valid received byte, data bits D0..D7 (D0 = bit 0)
//  ps2_state  out  1  1 = a valid byte is available in ps2_byte; sticky until rst low
// BEHAVIOUR
//  - Reset (rst=0, async): ps2_state=0, bit counter=0, shift reg=0, timeout counter=0,
//    sync flops=1 (idle). ps2_byte is NOT reset (holds last byte so the consumer can read it on
//    the ps2_state falling edge caused by reset); power-up value of ps2_byte = 8'h00.
//  - Inputs pass through SYNC_STAGES flops; falling edge = previous synced clk 1, current 0.
//    Data sampled from the synced data line in the same cycle the falling edge is detected.
//  - Frame: bit0 start (must be 0), bits1-8 data LSB first, bit9 odd parity, bit10 stop (must be 1).
//  - Counter 0..10 increments on each falling edge; on the 11th edge the frame is checked:
//    valid = start==0 && stop==1 && ^{data,parity}==1. Counter returns to 0 either way.
//  - Valid frame: one clk after the stop-bit edge, ps2_byte <= data and ps2_state <= 1.
//    Invalid frame: discarded silently; ps2_byte and ps2_state unchanged.
//  - ps2_state stays 1 until rst goes low; if another valid frame completes while 1, ps2_byte
//    is overwritten and ps2_state stays 1 (no overrun flag).
//  - Timeout: counter counts clk cycles while bit counter != 0 and resets on each falling edge;
//    reaching TIMEOUT_CYCLES clears bit counter and shift reg (partial frame dropped).
//    Timeout counter held at 0 when bit counter == 0.
//  - Reset mid-frame aborts the frame; next falling edge after release is treated as a start bit.
//  - rst is held low typically only a few cycles (combinational ack loop); no minimum pulse
//    beyond async-clear semantics; release is synchronised internally so no partial state.
//  - No transmit path; ps2k_clk/ps2k_data are inputs only.
// TESTING
//  - Send frame 0x1D (parity 1, stop 1) at ~12.5 kHz -> ps2_byte=8'h1D, ps2_state=1 one clk
//    after 11th falling edge; then drive rst=0 -> ps2_state=0 immediately, ps2_byte still 8'h1D.
//  - Sequence 0xF0 then 0x1D with rst pulsed after each ready -> two ps2_state rising edges,
//    ps2_byte 8'hF0 then 8'h1D.
//  - Frame 0x23 with wrong parity bit -> ps2_state stays 0, ps2_byte keeps previous value;
//    following good frame 0x29 -> ps2_byte=8'h29, ps2_state=1.
//  - 5 falling edges then idle > TIMEOUT_CYCLES, then full frame 0x1C -> ps2_byte=8'h1C, valid.
//  - rst=0 after 4 bits of a frame, release, send full frame 0x1B -> ps2_byte=8'h1B, ps2_state=1.
//  - Stop bit driven 0 on frame 0x1D -> no ps2_state assertion, counter back to 0.

Source files
------------

// File: rtl/ps2_keyboard_if.sv
// PS/2 keyboard receiver bus: raw keyboard lines in, received byte and ready flag out.
interface ps2_keyboard_if;
   logic       ps2k_clk;
   logic       ps2k_data;
   logic [7:0] ps2_byte;
   logic       ps2_state;

   modport slave  (input  ps2k_clk, ps2k_data, output ps2_byte, ps2_state);
   modport master (output ps2k_clk, ps2k_data, input  ps2_byte, ps2_state);
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: synchronises the keyboard lines, deframes 11-bit frames
// and presents each good scan-code byte with a sticky ready flag cleared by rst.
module ps2_keyboard #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic           clk,
   input  logic           rst,
   ps2_keyboard_if.slave  bus
);
   localparam int unsigned BIT_W    = 4;
   localparam int unsigned LAST_BIT = 10;
   localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]             r_rst_pipe;
   logic                   w_rst_n;
   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic                   r_clk_prev;
   logic                   w_clk_s;
   logic                   w_data_s;
   logic                   w_fall;
   logic [BIT_W-1:0]       r_bit_cnt;
   logic [9:0]             r_shift;
   logic [TO_W-1:0]        r_timeout;
   logic                   w_frame_end;
   logic                   w_frame_ok;
   logic                   r_state;
   logic [7:0]             r_byte;

   // Assert asynchronously, release two clocks later so no flop sees a partial release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_rst_pipe <= 2'b00;
      else      r_rst_pipe <= {r_rst_pipe[0], 1'b1};
   end
   assign w_rst_n = r_rst_pipe[1];

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_clk_sync  <= '1;
         r_data_sync <= '1;
         r_clk_prev  <= 1'b1;
      end else begin
         r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], bus.ps2k_clk};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.ps2k_data};
         r_clk_prev  <= w_clk_s;
      end
   end

   assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
   assign w_data_s = r_data_sync[SYNC_STAGES-1];
   assign w_fall   = r_clk_prev & ~w_clk_s;

   // r_shift holds bits 0..9 (start at [0], data [8:1], parity [9]); stop is the live sample.
   assign w_frame_end = w_fall && (r_bit_cnt == BIT_W'(LAST_BIT));
   assign w_frame_ok  = w_frame_end && !r_shift[0] && w_data_s && (^r_shift[9:1]);

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_timeout <= '0;
      end else if (w_fall) begin
         r_timeout <= '0;
         if (w_frame_end) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
         end else begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            r_shift   <= {w_data_s, r_shift[9:1]};
         end
      end else if (r_bit_cnt == '0) begin
         r_timeout <= '0;
      end else if (r_timeout == TO_W'(TIMEOUT_CYCLES - 1)) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_timeout <= '0;
      end else begin
         r_timeout <= r_timeout + TO_W'(1);
      end
   end

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n)        r_state <= 1'b0;
      else if (w_frame_ok) r_state <= 1'b1;
   end

   // Deliberately not reset: the consumer reads the byte while its ack holds rst low.
   always_ff @(posedge clk) begin
      if (w_frame_ok) r_byte <= r_shift[8:1];
   end

   assign bus.ps2_byte  = r_byte;
   assign bus.ps2_state = r_state;
endmodule

// File: tb/tb_ps2_keyboard.sv
// Bench for ps2_keyboard: table of directed frames, hand-written timeout/abort sequences
// and random frames checked against a frame-level reference model.
module tb_ps2_keyboard;
   localparam int unsigned TO   = 300;
   localparam int unsigned QTR  = 10;
   localparam int unsigned HALF = 20;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic       m_state;
   logic [7:0] m_byte;

   ps2_keyboard_if bus ();

   ps2_keyboard #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       flip_par;
      logic       bad_stop;
      logic       ack;
      logic       exp_state;
      logic [7:0] exp_byte;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] d, input logic flip_par,
                                              input logic bad_stop, input logic bad_start);
      logic par;
      par = (~^d) ^ flip_par;
      return {~bad_stop, par, d, bad_start};
   endfunction

   // Reference: a complete frame is accepted iff start=0, stop=1 and data+parity has odd weight.
   function automatic logic frame_valid(input logic [10:0] f);
      logic [8:0] dp;
      dp = f[9:1];
      return (f[0] == 1'b0) && (f[10] == 1'b1) && ($countones(dp) % 2 == 1);
   endfunction

   task automatic send_bits(input logic [10:0] frame, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         bus.ps2k_data = frame[i];
         repeat (QTR) @(negedge clk);
         bus.ps2k_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         bus.ps2k_clk = 1'b1;
         repeat (QTR) @(negedge clk);
      end
      @(negedge clk);
      bus.ps2k_data = 1'b1;
   endtask

   task automatic send_and_model(input logic [10:0] frame);
      send_bits(frame, 11);
      if (frame_valid(frame)) begin
         m_state = 1'b1;
         m_byte  = frame[8:1];
      end
   endtask

   task automatic pulse_ack(input string tag);
      @(negedge clk);
      rst = 1'b0;
      #1;
      m_state = 1'b0;
      check({tag, "_ack_state"}, 32'(bus.ps2_state), 32'(m_state));
      check({tag, "_ack_byte"}, 32'(bus.ps2_byte), 32'(m_byte));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      logic [10:0] f;
      total = 0;
      bad   = 0;
      m_state = 1'b0;
      m_byte  = 8'h00;
      rst = 1'b0;
      bus.ps2k_clk  = 1'b1;
      bus.ps2k_data = 1'b1;

      vecs[0] = '{8'h1D, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1D};
      vecs[1] = '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF0};
      vecs[2] = '{8'h1D, 1'b0, 1'b0, 1'b1, 1'b1, 8'h1D};
      vecs[3] = '{8'h23, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1D};
      vecs[4] = '{8'h29, 1'b0, 1'b0, 1'b0, 1'b1, 8'h29};
      vecs[5] = '{8'h1D, 1'b0, 1'b1, 1'b1, 1'b1, 8'h29};
      vecs[6] = '{8'h1D, 1'b0, 1'b1, 1'b0, 1'b0, 8'h29};
      vecs[7] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
      vecs[8] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF};

      repeat (3) @(negedge clk);
      check("reset_state", 32'(bus.ps2_state), 32'(0));
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_state", 32'(bus.ps2_state), 32'(0));

      for (int i = 0; i < 9; i++) begin
         f = make_frame(vecs[i].data, vecs[i].flip_par, vecs[i].bad_stop, 1'b0);
         send_and_model(f);
         check($sformatf("vec%0d_state", i), 32'(bus.ps2_state), 32'(vecs[i].exp_state));
         check($sformatf("vec%0d_byte", i), 32'(bus.ps2_byte), 32'(vecs[i].exp_byte));
         if (vecs[i].ack) pulse_ack($sformatf("vec%0d", i));
      end

      // Partial frame of 5 edges, idle past the timeout, then a full frame must deframe cleanly.
      send_bits(make_frame(8'h55, 1'b0, 1'b0, 1'b0), 5);
      repeat (TO + 50) @(negedge clk);
      check("timeout_no_state", 32'(bus.ps2_state), 32'(0));
      send_and_model(make_frame(8'h1C, 1'b0, 1'b0, 1'b0));
      check("timeout_state", 32'(bus.ps2_state), 32'(1));
      check("timeout_byte", 32'(bus.ps2_byte), 32'(8'h1C));
      pulse_ack("timeout");

      // Reset after 4 bits aborts the frame; the next edge is a fresh start bit.
      send_bits(make_frame(8'hA7, 1'b0, 1'b0, 1'b0), 4);
      pulse_ack("abort");
      send_and_model(make_frame(8'h1B, 1'b0, 1'b0, 1'b0));
      check("abort_state", 32'(bus.ps2_state), 32'(1));
      check("abort_byte", 32'(bus.ps2_byte), 32'(8'h1B));
      pulse_ack("abort2");

      // Latency: ready must appear within a few clocks of the 11th falling edge.
      begin
         int waited;
         f = make_frame(8'h3C, 1'b0, 1'b0, 1'b0);
         send_bits(f, 10);
         @(negedge clk);
         bus.ps2k_data = f[10];
         repeat (QTR) @(negedge clk);
         bus.ps2k_clk = 1'b0;
         waited = 0;
         while (bus.ps2_state !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
         end
         check("latency_state", 32'(bus.ps2_state), 32'(1));
         check("latency_byte", 32'(bus.ps2_byte), 32'(8'h3C));
         m_state = 1'b1;
         m_byte  = 8'h3C;
         repeat (HALF) @(negedge clk);
         bus.ps2k_clk = 1'b1;
         repeat (QTR) @(negedge clk);
         pulse_ack("latency");
      end

      for (int n = 0; n < 30; n++) begin
         logic [7:0] d;
         int unsigned kind;
         d    = 8'($urandom);
         kind = $urandom_range(0, 9);
         f = make_frame(d, kind == 7, kind == 8, kind == 9);
         send_and_model(f);
         check($sformatf("rand%0d_state", n), 32'(bus.ps2_state), 32'(m_state));
         check($sformatf("rand%0d_byte", n), 32'(bus.ps2_byte), 32'(m_byte));
         if ($urandom_range(0, 1) == 1) pulse_ack($sformatf("rand%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
